// File: rtl/hc_pkg.sv
// hc_pkg: shared constants and helpers for the 74HC595 emulation.
//   HC_DEFAULT_WIDTH : default shift/storage width
//   HC_SYNC_STAGES   : default pin synchroniser depth
//   clog2()          : ceiling log2, usable in constant expressions
package hc_pkg;

    localparam int HC_DEFAULT_WIDTH = 8;
    localparam int HC_SYNC_STAGES   = 2;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hc_sync.sv
// hc_sync: multi-stage flip-flop synchroniser for one asynchronous pin.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, every stage clears to 0
//   d     : asynchronous input
//   q     : synchronised output, STAGES clk cycles behind d
module hc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hc595_emu.sv
// hc595_emu: clock-sampled emulation of a 74HC595 shift/latch register.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   ser, srclk  : serial data and shift clock pins (shift on srclk rise)
//   rclk        : storage clock pin (latch on rclk rise)
//   srclr_n     : shift-register clear pin, active low (storage unaffected)
//   oe_n        : output enable pin, active low
//   q           : parallel outputs, q[0]=QA, optionally inverted
//   q_en        : pad drive enable (1 = drive)
//   qh_s        : cascade output QH'
//   bit_cnt     : shifts since last latch/clear, saturating at WIDTH
//   frame_done  : pulse, latch taken with a full frame shifted in
//   shift_ovf   : pulse, shift taken while bit_cnt was already WIDTH
module hc595_emu
    import hc_pkg::*;
#(
    parameter int WIDTH       = HC_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = HC_SYNC_STAGES,
    parameter bit INVERT_OUT  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ser,
    input  logic                        srclk,
    input  logic                        rclk,
    input  logic                        srclr_n,
    input  logic                        oe_n,
    output logic [WIDTH-1:0]            q,
    output logic                        q_en,
    output logic                        qh_s,
    output logic [clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                        frame_done,
    output logic                        shift_ovf
);

    localparam int CW = clog2(WIDTH + 1);

    logic             ser_s;
    logic             srclk_s;
    logic             rclk_s;
    logic             clr_s;
    logic             oe_n_s;
    logic             rdy_s;
    logic             srclk_d;
    logic             rclk_d;
    logic             sr_rise;
    logic             rc_rise;
    logic             cnt_full;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] storage;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cnt_nxt;

    // Identical depth on every pin keeps ser aligned with srclk.
    hc_sync #(.STAGES(SYNC_STAGES)) u_sync_ser   (.clk(clk), .rst_n(rst_n), .d(ser),     .q(ser_s));
    hc_sync #(.STAGES(SYNC_STAGES)) u_sync_srclk (.clk(clk), .rst_n(rst_n), .d(srclk),   .q(srclk_s));
    hc_sync #(.STAGES(SYNC_STAGES)) u_sync_rclk  (.clk(clk), .rst_n(rst_n), .d(rclk),    .q(rclk_s));
    hc_sync #(.STAGES(SYNC_STAGES)) u_sync_clr   (.clk(clk), .rst_n(rst_n), .d(srclr_n), .q(clr_s));
    hc_sync #(.STAGES(SYNC_STAGES)) u_sync_oe    (.clk(clk), .rst_n(rst_n), .d(oe_n),    .q(oe_n_s));

    // The oe_n chain resets to 0 (which reads as "enabled"); this chain of
    // constant 1s marks when oe_n_s carries a real pin sample, so q_en stays
    // low through reset and until the chain has filled.
    hc_sync #(.STAGES(SYNC_STAGES)) u_sync_rdy   (.clk(clk), .rst_n(rst_n), .d(1'b1),    .q(rdy_s));

    assign sr_rise  = srclk_s & ~srclk_d;
    assign rc_rise  = rclk_s & ~rclk_d;
    assign cnt_full = (bit_cnt == CW'(WIDTH));

    always_comb begin
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        if (!clr_s) begin
            shift_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            if (sr_rise) begin
                shift_nxt = {shift_reg[WIDTH-2:0], ser_s};
            end
            // A latch restarts the frame; a shift in the same cycle is its first bit.
            if (rc_rise) begin
                cnt_nxt = sr_rise ? CW'(1) : '0;
            end else if (sr_rise && !cnt_full) begin
                cnt_nxt = bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srclk_d    <= 1'b0;
            rclk_d     <= 1'b0;
            shift_reg  <= '0;
            storage    <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            shift_ovf  <= 1'b0;
        end else begin
            srclk_d    <= srclk_s;
            rclk_d     <= rclk_s;
            shift_reg  <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            // Storage takes the pre-shift value, so tied clocks lag by one stage.
            if (rc_rise) begin
                storage <= shift_reg;
            end
            frame_done <= rc_rise & cnt_full;
            shift_ovf  <= sr_rise & clr_s & cnt_full;
        end
    end

    assign q    = storage ^ {WIDTH{INVERT_OUT}};
    assign q_en = rdy_s & ~oe_n_s;
    assign qh_s = shift_reg[WIDTH-1];

endmodule

// File: tb/tb_hc595_emu.sv
module tb_hc595_emu;
    import hc_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int CW = clog2(W + 1);
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser = 1'b0;
    logic srclk = 1'b0;
    logic rclk = 1'b0;
    logic srclr_n = 1'b1;
    logic oe_n = 1'b0;

    logic [W-1:0]  q0, q1;
    logic          qen0, qen1, qh0, qh1, fd0, fd1, ov0, ov1;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    hc595_emu #(.WIDTH(W), .SYNC_STAGES(SS), .INVERT_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ser(ser), .srclk(srclk), .rclk(rclk),
        .srclr_n(srclr_n), .oe_n(oe_n), .q(q0), .q_en(qen0), .qh_s(qh0),
        .bit_cnt(cnt0), .frame_done(fd0), .shift_ovf(ov0)
    );

    hc595_emu #(.WIDTH(W), .SYNC_STAGES(SS), .INVERT_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ser(ser), .srclk(srclk), .rclk(rclk),
        .srclr_n(srclr_n), .oe_n(oe_n), .q(q1), .q_en(qen1), .qh_s(qh1),
        .bit_cnt(cnt1), .frame_done(fd1), .shift_ovf(ov1)
    );

    typedef struct {
        int    q;
        int    qh;
        int    cnt;
        int    qen;
        int    fd;
        int    ov;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: pin-level behaviour of the part, tracked as integers.
    int m_sr = 0;
    int m_st = 0;
    int m_cnt = 0;
    int m_oe = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: accumulates pulses, pops one expectation per settled step.
    int fd_seen = 0, ov_seen = 0, fd1_seen = 0, ov1_seen = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            fd_seen = 0; ov_seen = 0; fd1_seen = 0; ov1_seen = 0;
        end else begin
            fd_seen  += int'(fd0);
            ov_seen  += int'(ov0);
            fd1_seen += int'(fd1);
            ov1_seen += int'(ov1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".q"},     int'(q0),   e.q);
                chk({e.tag, ".q_inv"}, int'(q1),   e.q ^ MASK);
                chk({e.tag, ".qh_s"},  int'(qh0),  e.qh);
                chk({e.tag, ".qh_s1"}, int'(qh1),  e.qh);
                chk({e.tag, ".cnt"},   int'(cnt0), e.cnt);
                chk({e.tag, ".cnt1"},  int'(cnt1), e.cnt);
                chk({e.tag, ".q_en"},  int'(qen0), e.qen);
                chk({e.tag, ".q_en1"}, int'(qen1), e.qen);
                chk({e.tag, ".frame_done"},  fd_seen,  e.fd);
                chk({e.tag, ".frame_done1"}, fd1_seen, e.fd);
                chk({e.tag, ".shift_ovf"},   ov_seen,  e.ov);
                chk({e.tag, ".shift_ovf1"},  ov1_seen, e.ov);
                fd_seen = 0; ov_seen = 0; fd1_seen = 0; ov1_seen = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int fd, input int ov, input string tag);
        exp_t e;
        e.q   = m_st;
        e.qh  = (m_sr >> (W - 1)) & 1;
        e.cnt = m_cnt;
        e.qen = (m_oe != 0) ? 0 : 1;
        e.fd  = fd;
        e.ov  = ov;
        e.tag = tag;
        exp_q.push_back(e);
        cyc(2);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic op_shift(input int b);
        int ov;
        ser = b[0];
        cyc(1);
        srclk = 1'b1;
        cyc(SS + 3);
        srclk = 1'b0;
        cyc(SS + 2);
        ov = (m_cnt == W) ? 1 : 0;
        m_sr = (m_sr * 2 + b) % (1 << W);
        if (m_cnt < W) m_cnt++;
        push(0, ov, "shift");
    endtask

    task automatic op_latch(input bit timed);
        int fd;
        int lat;
        rclk = 1'b1;
        if (timed) begin
            lat = -1;
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk);
                #1;
                if (fd0 && lat < 0) lat = k;
            end
            chk("frame_done_latency", lat, SS + 1);
            @(negedge clk);
        end else begin
            cyc(SS + 3);
        end
        rclk = 1'b0;
        cyc(SS + 2);
        fd = (m_cnt == W) ? 1 : 0;
        m_st = m_sr;
        m_cnt = 0;
        push(fd, 0, "latch");
    endtask

    task automatic op_tied(input int b);
        int full;
        ser = b[0];
        cyc(1);
        srclk = 1'b1;
        rclk = 1'b1;
        cyc(SS + 3);
        srclk = 1'b0;
        rclk = 1'b0;
        cyc(SS + 2);
        full = (m_cnt == W) ? 1 : 0;
        m_st = m_sr;
        m_sr = (m_sr * 2 + b) % (1 << W);
        m_cnt = 1;
        push(full, full, "tied");
    endtask

    task automatic op_clear();
        srclr_n = 1'b0;
        cyc(SS + 3);
        srclr_n = 1'b1;
        cyc(SS + 2);
        m_sr = 0;
        m_cnt = 0;
        push(0, 0, "clear");
    endtask

    task automatic op_oe(input int v, input bit timed);
        int lat;
        oe_n = v[0];
        if (timed) begin
            lat = -1;
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk);
                #1;
                if (int'(qen0) == (v == 0 ? 1 : 0) && lat < 0) lat = k;
            end
            chk("q_en_latency", lat, SS);
            @(negedge clk);
        end else begin
            cyc(SS + 2);
        end
        m_oe = v;
        push(0, 0, "oe");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".q"},     int'(q0),   0);
        chk({tag, ".q_inv"}, int'(q1),   MASK);
        chk({tag, ".q_en"},  int'(qen0), 0);
        chk({tag, ".qh_s"},  int'(qh0),  0);
        chk({tag, ".cnt"},   int'(cnt0), 0);
        chk({tag, ".fd"},    int'(fd0),  0);
        chk({tag, ".ovf"},   int'(ov0),  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        cyc(3);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(SS + 2);
        push(0, 0, "post_reset");

        // T2: one frame, first bit ends at QH
        op_shift(1); op_shift(0); op_shift(1); op_shift(1);
        op_shift(0); op_shift(0); op_shift(1); op_shift(0);
        op_latch(1'b1);
        drain();
        chk("t2_q", int'(q0), 8'hB2);
        chk("t2_q_inv", int'(q1), 8'h4D);

        // T3: tied clocks, storage lags shift by one stage
        op_clear();
        op_latch(1'b0);
        for (int i = 0; i < 8; i++) op_tied(1);
        drain();
        chk("t3_q_8th", int'(q0), 8'h7F);
        op_tied(1);
        drain();
        chk("t3_q_9th", int'(q0), 8'hFF);

        // T4: clear leaves storage alone
        op_clear();
        for (int i = W - 1; i >= 0; i--) op_shift((8'hA5 >> i) & 1);
        op_latch(1'b0);
        op_clear();
        drain();
        chk("t4_q", int'(q0), 8'hA5);
        chk("t4_qh_s", int'(qh0), 0);
        chk("t4_cnt", int'(cnt0), 0);

        // T5: overflow and cascade
        op_clear();
        op_latch(1'b0);
        op_shift(1);
        for (int i = 0; i < 7; i++) op_shift(0);
        drain();
        chk("t5_qh_s_8th", int'(qh0), 1);
        chk("t5_cnt_8th", int'(cnt0), W);
        op_shift(0);
        drain();
        chk("t5_cnt_sat", int'(cnt0), W);

        // T6: output enable, q unaffected
        op_oe(1, 1'b1);
        drain();
        chk("t6_q_held", int'(q0), m_st);
        op_oe(0, 1'b1);

        // T1: asynchronous reset in the middle of activity
        op_shift(1);
        op_shift(1);
        op_latch(1'b0);
        drain();
        ser = 1'b1;
        srclk = 1'b1;
        rclk = 1'b1;
        cyc(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t1_async");
        srclk = 1'b0;
        rclk = 1'b0;
        ser = 1'b0;
        cyc(3);
        chk_reset_outputs("t1_held");
        rst_n = 1'b1;
        m_sr = 0; m_st = 0; m_cnt = 0; m_oe = 0;
        cyc(SS + 2);
        push(0, 0, "t1_after");

        // Randomised operation mix
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      op_shift(int'($urandom_range(0, 1)));
            else if (r < 65) op_latch(1'b0);
            else if (r < 77) op_tied(int'($urandom_range(0, 1)));
            else if (r < 87) op_clear();
            else             op_oe(int'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
